// File: rtl/branch_target_table_pkg.sv
// ---------------------------------------------------------------------------
// branch_target_table_pkg
// Shared CPU package for the fetch-stage branch-target table.
//   - state enum for the table's init/ready state machine
//   - default key / program-counter widths
//   - named branch-key indices shared by the assembler/decoder and the RTL,
//     so software and hardware agree on which table slot means what
// ---------------------------------------------------------------------------
package branch_target_table_pkg;

    // Default widths used by the CPU top level
    localparam int BTT_KEY_W = 5;
    localparam int BTT_PC_W  = 12;

    // Table state: sweeping entries clear after reset, then operating
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } btt_state_t;

    // Named branch keys emitted by the assembler
    localparam logic [BTT_KEY_W-1:0] KEY_INNERLOOP = 5'd2;
    localparam logic [BTT_KEY_W-1:0] KEY_DONE      = 5'd3;
    localparam logic [BTT_KEY_W-1:0] KEY_OUTERLOOP = 5'd4;
    localparam logic [BTT_KEY_W-1:0] KEY_ERROR     = 5'd5;

endpackage : branch_target_table_pkg

// File: rtl/branch_target_table_storage.sv
// ---------------------------------------------------------------------------
// btt_storage
// DEPTH x (1+PC_W) register array holding {valid, target} per entry.
// One synchronous write port, one asynchronous (combinational) read port.
// Storage has no reset; the owning table clears it with an init sweep.
//
// Ports:
//   clk        in   clock, rising edge
//   wr_en      in   write entry wr_key this cycle
//   wr_key     in   KEY_W  index to write
//   wr_valid   in   valid bit to store
//   wr_target  in   PC_W   target to store
//   rd_key     in   KEY_W  index to read
//   rd_valid   out  valid bit of entry rd_key
//   rd_target  out  PC_W   target of entry rd_key
// ---------------------------------------------------------------------------
module btt_storage #(
    parameter int KEY_W = 5,
    parameter int PC_W  = 12,
    parameter int DEPTH = 2**KEY_W
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [KEY_W-1:0] wr_key,
    input  logic             wr_valid,
    input  logic [PC_W-1:0]  wr_target,
    input  logic [KEY_W-1:0] rd_key,
    output logic             rd_valid,
    output logic [PC_W-1:0]  rd_target
);

    // Entry layout: bit PC_W is the valid flag, low bits are the target
    logic [PC_W:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_key] <= {wr_valid, wr_target};
        end
    end

    assign rd_valid  = mem[rd_key][PC_W];
    assign rd_target = mem[rd_key][PC_W-1:0];

endmodule : btt_storage

// File: rtl/branch_target_table.sv
// ---------------------------------------------------------------------------
// branch_target_table
// Programmable branch-target lookup for the fetch stage. Maps a KEY_W-bit
// branch key to a PC_W-bit absolute target. After reset an init sweep
// clears every entry (one per cycle, DEPTH cycles) before lookups and
// writes are accepted. Lookup results are registered (one-cycle latency),
// with write-first bypass when a write and lookup hit the same key.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   lookup_en   in   request a lookup this cycle
//   key         in   KEY_W  lookup key
//   wr_en       in   write an entry this cycle
//   wr_key      in   KEY_W  entry index to write
//   wr_target   in   PC_W   target value to write
//   wr_clear    in   with wr_en, invalidate the entry instead
//   ready       out  table initialised
//   branch_pos  out  PC_W   registered target, 0 when no hit
//   hit         out  registered: last lookup found a valid entry
//   miss        out  registered: last lookup found an invalid entry
// ---------------------------------------------------------------------------
module branch_target_table
    import branch_target_table_pkg::*;
#(
    parameter int KEY_W = BTT_KEY_W,
    parameter int PC_W  = BTT_PC_W,
    parameter int DEPTH = 2**KEY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_en,
    input  logic [KEY_W-1:0] key,
    input  logic             wr_en,
    input  logic [KEY_W-1:0] wr_key,
    input  logic [PC_W-1:0]  wr_target,
    input  logic             wr_clear,
    output logic             ready,
    output logic [PC_W-1:0]  branch_pos,
    output logic             hit,
    output logic             miss
);

    localparam logic [KEY_W-1:0] LAST_IDX = KEY_W'(DEPTH - 1);

    btt_state_t       state;
    logic [KEY_W-1:0] init_cnt;

    logic             st_wr_en;
    logic [KEY_W-1:0] st_wr_key;
    logic             st_wr_valid;
    logic [PC_W-1:0]  st_wr_target;
    logic             rd_valid;
    logic [PC_W-1:0]  rd_target;

    logic             bypass;
    logic             look_valid;
    logic [PC_W-1:0]  look_target;

    // Init sweep: clear one entry per cycle; the state change (not counter
    // overflow) ends the sweep, so init_cnt just wraps and is then ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + KEY_W'(1);
                    if (init_cnt == LAST_IDX) begin
                        state <= READY;
                    end
                end
                READY:   state <= READY;
                default: state <= INIT;
            endcase
        end
    end

    assign ready = (state == READY);

    // The single storage write port is shared: the sweep owns it during
    // INIT, user writes own it once ready. A clear stores target 0.
    always_comb begin
        st_wr_en     = 1'b0;
        st_wr_key    = wr_key;
        st_wr_valid  = 1'b0;
        st_wr_target = '0;
        if (!ready) begin
            st_wr_en  = 1'b1;
            st_wr_key = init_cnt;
        end else if (wr_en) begin
            st_wr_en     = 1'b1;
            st_wr_valid  = ~wr_clear;
            st_wr_target = wr_clear ? '0 : wr_target;
        end
    end

    btt_storage #(
        .KEY_W (KEY_W),
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk       (clk),
        .wr_en     (st_wr_en),
        .wr_key    (st_wr_key),
        .wr_valid  (st_wr_valid),
        .wr_target (st_wr_target),
        .rd_key    (key),
        .rd_valid  (rd_valid),
        .rd_target (rd_target)
    );

    // Write-first bypass: a same-cycle write to the looked-up key wins over
    // the stored contents. Only meaningful when ready (gated below).
    always_comb begin
        bypass      = wr_en && (wr_key == key);
        look_valid  = rd_valid;
        look_target = rd_target;
        if (bypass) begin
            look_valid  = ~wr_clear;
            look_target = wr_clear ? '0 : wr_target;
        end
    end

    // Outputs are rebuilt every cycle; 0 means "no branch" so they never
    // hold a stale target from an earlier lookup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_pos <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else if (ready && lookup_en) begin
            branch_pos <= look_valid ? look_target : '0;
            hit        <= look_valid;
            miss       <= ~look_valid;
        end else begin
            branch_pos <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end
    end

endmodule : branch_target_table

// File: tb/tb_branch_target_table.sv
// ---------------------------------------------------------------------------
// tb_branch_target_table
// Self-checking bench for branch_target_table. A behavioural model keeps an
// array of {valid, target} plus a count of clock edges since reset; the
// table is ready once that count reaches DEPTH. Each scenario task drives
// stimulus and compares the DUT outputs against the model and constants.
// ---------------------------------------------------------------------------
module tb_branch_target_table;
    import branch_target_table_pkg::*;

    localparam int KEY_W = 5;
    localparam int PC_W  = 12;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             lookup_en = 1'b0;
    logic [KEY_W-1:0] key = '0;
    logic             wr_en = 1'b0;
    logic [KEY_W-1:0] wr_key = '0;
    logic [PC_W-1:0]  wr_target = '0;
    logic             wr_clear = 1'b0;
    logic             ready;
    logic [PC_W-1:0]  branch_pos;
    logic             hit;
    logic             miss;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit              m_valid  [DEPTH];
    logic [PC_W-1:0] m_target [DEPTH];
    int              m_cycles;
    logic [PC_W-1:0] exp_pos;
    logic            exp_hit;
    logic            exp_miss;
    logic            exp_ready;

    branch_target_table #(
        .KEY_W (KEY_W),
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lookup_en  (lookup_en),
        .key        (key),
        .wr_en      (wr_en),
        .wr_key     (wr_key),
        .wr_target  (wr_target),
        .wr_clear   (wr_clear),
        .ready      (ready),
        .branch_pos (branch_pos),
        .hit        (hit),
        .miss       (miss)
    );

    always #5 clk = ~clk;

    // Pulse reset at a falling edge and forget everything the model knew.
    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        lookup_en = 1'b0;
        wr_en     = 1'b0;
        wr_clear  = 1'b0;
        m_cycles  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i]  = 1'b0;
            m_target[i] = '0;
        end
        exp_pos   = '0;
        exp_hit   = 1'b0;
        exp_miss  = 1'b0;
        exp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the registered outputs from the
    // model, advance past the rising edge and update the model.
    task automatic do_cycle(input bit le, input int k, input bit we,
                            input int wk, input int wt, input bit wc);
        bit rdy;
        lookup_en = le;
        key       = k[KEY_W-1:0];
        wr_en     = we;
        wr_key    = wk[KEY_W-1:0];
        wr_target = wt[PC_W-1:0];
        wr_clear  = wc;
        rdy = (m_cycles >= DEPTH);
        exp_pos  = '0;
        exp_hit  = 1'b0;
        exp_miss = 1'b0;
        if (rdy && le) begin
            if (we && wk == k) begin
                exp_hit  = !wc;
                exp_miss = wc;
                exp_pos  = wc ? '0 : wt[PC_W-1:0];
            end else if (m_valid[k]) begin
                exp_hit = 1'b1;
                exp_pos = m_target[k];
            end else begin
                exp_miss = 1'b1;
            end
        end
        if (rdy && we) begin
            m_valid[wk]  = !wc;
            m_target[wk] = wc ? '0 : wt[PC_W-1:0];
        end
        @(posedge clk);
        #1;
        m_cycles++;
        exp_ready = (m_cycles >= DEPTH);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (m_cycles < DEPTH && guard < 2 * DEPTH) begin
            do_cycle(0, 0, 0, 0, 0, 0);
            guard++;
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || hit !== 1'b0 || miss !== 1'b0 || branch_pos !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs ready=%b hit=%b miss=%b pos=%0d required all 0",
                     ready, hit, miss, branch_pos);
        end
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(0, 0, 0, 0, 0, 0);
            checks++;
            if (ready !== (i == DEPTH - 1)) begin
                failures++;
                $display("[TB] FAIL init_ready edge=%0d ready=%b required %b",
                         i + 1, ready, (i == DEPTH - 1));
            end
            checks++;
            if (hit !== 1'b0 || miss !== 1'b0 || branch_pos !== '0) begin
                failures++;
                $display("[TB] FAIL init_outputs edge=%0d hit=%b miss=%b pos=%0d required 0",
                         i + 1, hit, miss, branch_pos);
            end
        end
    endtask

    task automatic test_directed_lookup();
        $display("[TB] test_directed_lookup");
        do_cycle(0, 0, 1, int'(KEY_DONE), 16, 0);
        do_cycle(0, 0, 1, int'(KEY_INNERLOOP), 69, 0);
        do_cycle(1, 3, 0, 0, 0, 0);
        checks++;
        if (branch_pos !== 12'd16 || hit !== 1'b1 || miss !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lookup_key3 pos=%0d hit=%b miss=%b required pos=16 hit=1 miss=0",
                     branch_pos, hit, miss);
        end
        do_cycle(1, 2, 0, 0, 0, 0);
        checks++;
        if (branch_pos !== 12'd69 || hit !== 1'b1 || miss !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lookup_key2 pos=%0d hit=%b miss=%b required pos=69 hit=1 miss=0",
                     branch_pos, hit, miss);
        end
        do_cycle(1, 7, 0, 0, 0, 0);
        checks++;
        if (branch_pos !== 12'd0 || hit !== 1'b0 || miss !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lookup_key7 pos=%0d hit=%b miss=%b required pos=0 hit=0 miss=1",
                     branch_pos, hit, miss);
        end
        do_cycle(0, 3, 0, 0, 0, 0);
        checks++;
        if (branch_pos !== 12'd0 || hit !== 1'b0 || miss !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_lookup pos=%0d hit=%b miss=%b required all 0",
                     branch_pos, hit, miss);
        end
    endtask

    task automatic test_bypass();
        $display("[TB] test_bypass");
        do_cycle(1, 4, 1, 4, 55, 0);
        checks++;
        if (branch_pos !== 12'd55 || hit !== 1'b1 || miss !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bypass_write pos=%0d hit=%b miss=%b required pos=55 hit=1 miss=0",
                     branch_pos, hit, miss);
        end
        do_cycle(1, 4, 1, 4, 0, 1);
        checks++;
        if (branch_pos !== 12'd0 || hit !== 1'b0 || miss !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bypass_clear pos=%0d hit=%b miss=%b required pos=0 hit=0 miss=1",
                     branch_pos, hit, miss);
        end
        // Different keys: lookup of key 3 sees old 16 while key 9 is written
        do_cycle(1, 3, 1, 9, 777, 0);
        checks++;
        if (branch_pos !== 12'd16 || hit !== 1'b1) begin
            failures++;
            $display("[TB] FAIL diff_key_old pos=%0d hit=%b required pos=16 hit=1",
                     branch_pos, hit);
        end
        do_cycle(1, 9, 0, 0, 0, 0);
        checks++;
        if (branch_pos !== 12'd777 || hit !== 1'b1) begin
            failures++;
            $display("[TB] FAIL diff_key_new pos=%0d hit=%b required pos=777 hit=1",
                     branch_pos, hit);
        end
    endtask

    task automatic test_reset_mid_init();
        int ready_edge;
        $display("[TB] test_reset_mid_init");
        apply_reset();
        for (int i = 0; i < 10; i++) do_cycle(0, 0, 0, 0, 0, 0);
        apply_reset();
        ready_edge = -1;
        for (int i = 0; i < DEPTH + 4 && ready_edge < 0; i++) begin
            do_cycle(0, 0, 0, 0, 0, 0);
            if (ready === 1'b1) ready_edge = i + 1;
        end
        checks++;
        if (ready_edge != DEPTH) begin
            failures++;
            $display("[TB] FAIL restart_init_len edges=%0d required %0d", ready_edge, DEPTH);
        end
        do_cycle(0, 0, 1, int'(KEY_DONE), 16, 0);
        do_cycle(1, 3, 0, 0, 0, 0);
        checks++;
        if (branch_pos !== 12'd16 || hit !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset_key3 pos=%0d hit=%b required pos=16 hit=1",
                     branch_pos, hit);
        end
        apply_reset();
        ready_edge = -1;
        for (int i = 0; i < DEPTH + 4 && ready_edge < 0; i++) begin
            do_cycle(0, 0, 0, 0, 0, 0);
            if (ready === 1'b1) ready_edge = i + 1;
        end
        checks++;
        if (ready_edge != DEPTH) begin
            failures++;
            $display("[TB] FAIL ready_reset_init_len edges=%0d required %0d", ready_edge, DEPTH);
        end
        do_cycle(1, 3, 0, 0, 0, 0);
        checks++;
        if (branch_pos !== 12'd0 || hit !== 1'b0 || miss !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cleared_key3 pos=%0d hit=%b miss=%b required pos=0 hit=0 miss=1",
                     branch_pos, hit, miss);
        end
    endtask

    task automatic test_init_ignored();
        $display("[TB] test_init_ignored");
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1, 5, 1, 5, 59, 0);
            checks++;
            if (hit !== 1'b0 || miss !== 1'b0 || branch_pos !== '0) begin
                failures++;
                $display("[TB] FAIL init_ignore edge=%0d hit=%b miss=%b pos=%0d required all 0",
                         i + 1, hit, miss, branch_pos);
            end
        end
        do_cycle(1, int'(KEY_ERROR), 0, 0, 0, 0);
        checks++;
        if (branch_pos !== 12'd0 || hit !== 1'b0 || miss !== 1'b1) begin
            failures++;
            $display("[TB] FAIL key5_after_init pos=%0d hit=%b miss=%b required pos=0 hit=0 miss=1",
                     branch_pos, hit, miss);
        end
    endtask

    task automatic test_random();
        int k;
        int wk;
        $display("[TB] test_random");
        for (int n = 0; n < 600; n++) begin
            if (n == 300) apply_reset();
            k  = $urandom_range(0, DEPTH - 1);
            wk = ($urandom_range(0, 3) == 0) ? k : $urandom_range(0, DEPTH - 1);
            do_cycle($urandom_range(0, 3) != 0, k, $urandom_range(0, 1) == 1, wk,
                     $urandom_range(0, 4095), $urandom_range(0, 3) == 0);
            checks++;
            if (branch_pos !== exp_pos || hit !== exp_hit || miss !== exp_miss || ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL random n=%0d pos=%0d hit=%b miss=%b ready=%b required pos=%0d hit=%b miss=%b ready=%b",
                         n, branch_pos, hit, miss, ready, exp_pos, exp_hit, exp_miss, exp_ready);
            end
            checks++;
            if (hit === 1'b1 && miss === 1'b1) begin
                failures++;
                $display("[TB] FAIL hit_miss_exclusive n=%0d hit=%b miss=%b required not both", n, hit, miss);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_lookup();
        test_bypass();
        test_reset_mid_init();
        test_init_ignored();
        wait_ready();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_branch_target_table

// File: doc/branch_target_table.md
Name: branch_target_table

Overview:
- Programmable, parametrised branch-target lookup table for the CPU fetch stage.
- Maps a KEY_W-bit branch key from the instruction to a PC_W-bit absolute branch target.
- Entries are written at run time through a write port, replacing hard-wired targets. Each entry carries a valid bit, and a lookup of an invalid entry reports a miss.
- Lookup output is registered, one-cycle latency. After reset, an init sweep clears the table before lookups are accepted.

Parameters:
- KEY_W, 5, branch key width.
- PC_W, 12, branch target / program counter width.
- DEPTH, 2**KEY_W, number of entries. Must equal 2**KEY_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- lookup_en  in  1  request a lookup this cycle.
- key  in  KEY_W  lookup key.
- wr_en  in  1  write an entry this cycle.
- wr_key  in  KEY_W  entry index to write.
- wr_target  in  PC_W  target value to write.
- wr_clear  in  1  with wr_en: invalidate the entry instead of writing a target.
- ready  out  1  table initialised; lookups and writes accepted.
- branch_pos  out  PC_W  registered target. 0 when no hit.
- hit  out  1  registered: previous-cycle lookup found a valid entry.
- miss  out  1  registered: previous-cycle lookup found an invalid entry.

Behaviour:
- State machine, two states:
  - INIT: init_cnt (KEY_W bits) steps 0 to DEPTH-1, clearing one entry per cycle (valid=0, target=0). After the entry at DEPTH-1 is cleared, the next state is READY. INIT lasts exactly DEPTH cycles.
  - READY: normal operation. No exit except reset.
- Reset (async, any time, including mid-INIT or mid-write):
  - state=INIT, init_cnt=0, ready=0, branch_pos=0, hit=0, miss=0.
  - Table storage is not reset directly; the INIT sweep clears it.
- ready is high exactly when state==READY, driven from the state register.
- Writes:
  - Accepted only when ready=1; ignored in INIT.
  - wr_en=1 and wr_clear=0: entry[wr_key] takes target=wr_target, valid=1 at the clock edge.
  - wr_en=1 and wr_clear=1: entry[wr_key] takes valid=0, target=0.
- Lookups:
  - Accepted only when ready=1.
  - On the edge after lookup_en=1:
    - Entry valid: branch_pos=target, hit=1, miss=0.
    - Entry invalid: branch_pos=0, hit=0, miss=1.
  - lookup_en=0, or ready=0: the next edge gives branch_pos=0, hit=0, miss=0. Outputs do not hold the previous value; 0 means "no branch", so PC advances normally.
- Same-cycle write and lookup to the same key: the lookup returns the written value (write-first bypass).
  - Write with clear: miss=1.
  - Write with target: hit=1, branch_pos=wr_target.
- Same-cycle write and lookup to different keys: independent; the lookup sees the old contents.
- Back-to-back lookups: one per cycle, fully pipelined, no stalls.
- hit and miss are mutually exclusive. Both are 0 in INIT.
- Widths: all arithmetic unsigned. init_cnt wraps naturally at DEPTH-1; the state change ends the sweep, not overflow detection.
- Keys are always in range because DEPTH=2**KEY_W. No out-of-range handling.

Decomposition:
- Shared CPU package holds:
  - State enum: INIT, READY.
  - Default widths: KEY_W=5, PC_W=12.
  - Named branch-key constants used by the assembler/decoder (e.g. KEY_DONE, KEY_INNERLOOP), so software and RTL agree on indices.
- One sub-module: btt_storage. DEPTH x (1+PC_W) register array, one synchronous write port, one asynchronous read port.
- Top level holds the FSM, init counter, bypass mux and output registers.

Test Plan:
- Reset then idle, DEPTH=32:
  - ready=0 for exactly 32 cycles after reset deasserts, then ready=1.
  - branch_pos/hit/miss stay 0 throughout.
- After ready: write key 3 -> 16, key 2 -> 69. Lookup 3, 2, 7 on consecutive cycles:
  - Outputs one cycle later in order: (16, hit), (69, hit), (0, miss).
- Same-cycle write and lookup of key 4 -> 55: next cycle branch_pos=55, hit=1.
- Same-cycle clear of key 4 with lookup of key 4: next cycle branch_pos=0, miss=1.
- Reset mid-INIT at cycle 10, then again after READY with key 3 -> 16 programmed:
  - Each reset restarts the full 32-cycle INIT.
  - A post-READY lookup of key 3 gives miss=1.
- Write and lookup attempted during INIT (key 5 -> 59):
  - Both ignored; outputs stay 0.
  - After ready, lookup of key 5 gives miss=1.
